mem_stack_seq: RTL and testbench
================================

Name: mem_stack_seq

Overview:
Sequencer for the memory stage's stack traffic. It owns the architectural stack pointer and expands PUSH, POP, CALL, RET, INT and RTI into one to three 16-bit stack beats. It drives the memory-stage read/write, address-select and data-select controls and stalls the pipeline until the last beat issues. It also returns the popped 32-bit PC and flags for RET and RTI.

Parameters:
W, 16, data/stack-pointer width
SP_INIT, 16'h07FF, stack-pointer value after reset (top of 2K-word memory)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op_valid  in  1  stack op presented by the memory stage this cycle
op_code  in  3  stack opcode (package enum: NOP, PUSH, POP, CALL, RET, INT, RTI)
mem_rd_data  in  W  memory read data (asynchronous-read memory, valid in the same cycle)
seq_active  out  1  a beat is issuing; memory-stage controls come from this block
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
mem_addr_sel  out  2  address-mux select (always ADDR_SP while active)
mem_data_sel  out  3  data-mux select
sp_addr  out  W  stack address for this beat; feeds the sp input of the address mux
sp  out  W  current stack pointer
stall  out  1  hold the pipeline front-end
pc_out  out  2*W  popped PC
pc_load  out  1  one-cycle pulse: load pc_out into the PC
flags_out  out  3  popped flags
flags_load  out  1  one-cycle pulse: load flags_out

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE, sp=SP_INIT.
  - All other outputs 0; hi/lo/flag capture registers 0.
  - Any op in flight is abandoned mid-sequence with no partial pc_load/flags_load.
- Stack convention: sp points at the next free word.
  - Push beat: writes mem[sp], sp_addr=sp; sp decrements at the end of the beat.
  - Pop beat: reads mem[sp+1], sp_addr=sp+1; sp increments at the end of the beat.
  - All sp arithmetic is modulo 2^W with no overflow detection; memory uses sp_addr[10:0].
- Acceptance: op accepted in cycle T when state==IDLE and op_valid=1 and op_code is not NOP.
  - NOP and undefined codes: no beats, no stall.
  - op_valid while not IDLE is ignored; the pipeline is stalled and holds the op.
- Beats issue in cycles T+1..T+N, one per cycle, from registered state.
  - stall=1 in cycles T..T+N-1 (combinational in T), 0 in T+N so the pipeline advances on the last beat.
- Beat sequences (data_sel in beat order):
  - PUSH (N=1): write DATA_RSRC.
  - POP (N=1): read; data goes to write-back through the normal RD path.
  - CALL (N=2): write DATA_PCP_HI, then DATA_PCP_LO.
  - INT (N=3): write DATA_PC_HI, DATA_PC_LO, DATA_FLAGS.
  - RET (N=2): read LO (captured), then read HI.
    - In beat 2: pc_out={mem_rd_data, lo_reg}, pc_load=1.
  - RTI (N=3): read FLAGS (captured), then LO (captured), then HI.
    - In beat 3: pc_out={mem_rd_data, lo_reg}, flags_out=flag_reg, pc_load=flags_load=1.
- Outputs by state:
  - In IDLE: mem_read, mem_write, seq_active, pc_load and flags_load are 0; mem_addr_sel and mem_data_sel are 0.
  - During beats: seq_active=1 and exactly one of mem_read/mem_write is 1.
- Return to IDLE after beat N. A new op may be accepted in the cycle after the final beat, giving back-to-back throughput of N+1 cycles per op.
- State machine: IDLE -> B1 -> B2 -> B3 -> IDLE.
  - Beat count and direction are latched at acceptance.
  - The PUSH/POP path skips to IDLE after B1; CALL/RET skip to IDLE after B2.

Decomposition:
- Package mem_seq_pkg holds:
  - op enum: NOP=0, PUSH=1, POP=2, CALL=3, RET=4, INT=5, RTI=6; 7 is reserved and treated as NOP.
  - State enum: IDLE, B1, B2, B3.
  - Address selects: ADDR_RSRC=0, ADDR_RDST=1, ADDR_ALU=2, ADDR_SP=3.
  - Data selects: DATA_RSRC=0, DATA_RDST=1, DATA_FLAGS=2, DATA_PC_HI=3, DATA_PC_LO=4, DATA_PCP_HI=5, DATA_PCP_LO=6, DATA_ZERO=7.
- One sub-module, stack_ptr:
  - Inputs: inc, dec, async active-low reset to SP_INIT.
  - Outputs: sp and sp+1.

Test Plan:
- Reset: assert rst=0 mid-idle -> sp=16'h07FF, stall=0, all enables 0, pc_load=0.
- CALL at sp=07FF:
  - T: stall=1.
  - T+1: write, data_sel=5, sp_addr=07FF, stall=1.
  - T+2: write, data_sel=6, sp_addr=07FE, stall=0.
  - Final sp=07FD.
- RET following CALL (memory holds 07FF=0x0001, 07FE=0x2345):
  - Beat 1: read at 07FE.
  - Beat 2: read at 07FF, pc_load=1, pc_out=32'h0001_2345.
  - Final sp=07FF.
- INT with flags=3'b101, then RTI:
  - Writes go to 07FF/07FE/07FD with data_sel 3, 4, 2.
  - RTI reads 07FD, 07FE, 07FF.
  - Beat 3: flags_out=3'b101, pc_out=original PC, both load pulses high for exactly 1 cycle.
- Reset asserted during INT beat 2 -> all outputs 0 immediately (asynchronous), sp=07FF, no load pulse; next op starts cleanly.
- Back-to-back and wrap:
  - op_valid held high: PUSH accepted, ignored during its beat, next PUSH accepted the cycle after.
  - With sp forced via reset SP_INIT=16'h0000: PUSH writes 0000 and sp becomes FFFF; then POP reads at 0000 and sp returns to 0000.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: opcode, state, mux-select encodings and per-beat control decode for the stack sequencer
package mem_seq_pkg;
   typedef enum logic [2:0] {NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, CALL = 3'd3, RET = 3'd4, INT = 3'd5, RTI = 3'd6} op_e;
   typedef enum logic [1:0] {IDLE, B1, B2, B3} state_e;
   typedef enum logic [1:0] {ADDR_RSRC = 2'd0, ADDR_RDST = 2'd1, ADDR_ALU = 2'd2, ADDR_SP = 2'd3} addr_sel_e;
   typedef enum logic [2:0] {
      DATA_RSRC = 3'd0, DATA_RDST = 3'd1, DATA_FLAGS = 3'd2, DATA_PC_HI = 3'd3,
      DATA_PC_LO = 3'd4, DATA_PCP_HI = 3'd5, DATA_PCP_LO = 3'd6, DATA_ZERO = 3'd7
   } data_sel_e;
   typedef struct packed {
      logic      rd;
      logic      wr;
      data_sel_e dsel;
      logic      pcl;
      logic      fll;
      logic      last;
   } beat_t;
   function automatic beat_t beat_ctl(input op_e op, input state_e b);
      beat_t c;
      c = '0;
      c.wr = op inside {PUSH, CALL, INT};
      c.rd = op inside {POP, RET, RTI};
      c.last = (b == B1 && op inside {PUSH, POP}) || (b == B2 && op inside {CALL, RET}) || b == B3;
      c.pcl = (b == B2 && op == RET) || (b == B3 && op == RTI);
      c.fll = b == B3 && op == RTI;
      c.dsel = op == CALL ? (b == B1 ? DATA_PCP_HI : DATA_PCP_LO) :
               op == INT  ? (b == B1 ? DATA_PC_HI : b == B2 ? DATA_PC_LO : DATA_FLAGS) : DATA_RSRC;
      return c;
   endfunction
endpackage

// File: rtl/mem_stack_seq_stack_ptr.sv
// stack_ptr: architectural stack pointer with increment/decrement and a precomputed sp+1
module stack_ptr #(
   parameter int             W       = 16,
   parameter logic [W-1:0]   SP_INIT = 16'h07FF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] sp,
   output logic [W-1:0] sp_p1
);
   assign sp_p1 = sp + W'(1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) sp <= SP_INIT;
      else if (inc ^ dec) sp <= inc ? sp_p1 : sp - W'(1);
endmodule

// File: rtl/mem_stack_seq.sv
// mem_stack_seq: expands stack ops into 1-3 memory beats, owns sp, stalls the front-end and returns popped PC/flags
module mem_stack_seq
   import mem_seq_pkg::*;
#(
   parameter int           W       = 16,
   parameter logic [W-1:0] SP_INIT = 16'h07FF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           op_valid,
   input  logic [2:0]     op_code,
   input  logic [W-1:0]   mem_rd_data,
   output logic           seq_active,
   output logic           mem_read,
   output logic           mem_write,
   output logic [1:0]     mem_addr_sel,
   output logic [2:0]     mem_data_sel,
   output logic [W-1:0]   sp_addr,
   output logic [W-1:0]   sp,
   output logic           stall,
   output logic [2*W-1:0] pc_out,
   output logic           pc_load,
   output logic [2:0]     flags_out,
   output logic           flags_load
);
   state_e       state, nxt;
   op_e          op_q;
   beat_t        cur;
   logic [W-1:0] lo_reg, sp_p1;
   logic [2:0]   flag_reg;
   logic         accept;
   assign accept = rst && state == IDLE && op_valid && op_code inside {[3'd1:3'd6]};
   assign nxt = state == B1 ? B2 : B3;
   // cur holds the control word of the beat issuing now, so memory controls come straight from flops
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= IDLE;
         op_q     <= NOP;
         cur      <= '0;
         lo_reg   <= '0;
         flag_reg <= '0;
      end else begin
         if (state == IDLE) begin
            if (accept) begin
               state <= B1;
               op_q  <= op_e'(op_code);
               cur   <= beat_ctl(op_e'(op_code), B1);
            end
         end else if (cur.last) begin
            state <= IDLE;
            cur   <= '0;
         end else begin
            state <= nxt;
            cur   <= beat_ctl(op_q, nxt);
         end
         // non-final pops of RET/RTI: RTI pops flags first, every other early pop is the PC low half
         if (cur.rd && !cur.last) begin
            if (op_q == RTI && state == B1) flag_reg <= mem_rd_data[2:0];
            else lo_reg <= mem_rd_data;
         end
      end
   stack_ptr #(.W(W), .SP_INIT(SP_INIT)) u_sp (
      .clk   (clk),
      .rst   (rst),
      .inc   (cur.rd),
      .dec   (cur.wr),
      .sp    (sp),
      .sp_p1 (sp_p1)
   );
   assign seq_active   = state != IDLE;
   assign mem_read     = cur.rd;
   assign mem_write    = cur.wr;
   assign mem_data_sel = cur.dsel;
   assign mem_addr_sel = seq_active ? ADDR_SP : ADDR_RSRC;
   assign sp_addr      = cur.rd ? sp_p1 : cur.wr ? sp : '0;
   assign stall        = seq_active ? !cur.last : accept;
   assign pc_load      = cur.pcl;
   assign flags_load   = cur.fll;
   assign pc_out       = cur.pcl ? {mem_rd_data, lo_reg} : '0;
   assign flags_out    = cur.fll ? flag_reg : '0;
endmodule

// File: tb/tb_mem_stack_seq.sv
// tb_mem_stack_seq: scoreboard bench; each issued op queues its expected beats, the monitor pops one per active beat
module tb_mem_stack_seq;
   logic        clk = 0, rst = 0, op_valid = 0, op_valid1 = 0;
   logic [2:0]  op_code = 0;
   logic [15:0] rsrc = 16'h1111, rdst = 16'h2222, wdata, mem_rd_data;
   logic [31:0] pc = 0, pcp = 0;
   logic [2:0]  flags = 0;
   logic        seq_active, mem_read, mem_write, stall, pc_load, flags_load;
   logic [1:0]  mem_addr_sel;
   logic [2:0]  mem_data_sel, flags_out;
   logic [15:0] sp_addr, sp;
   logic [31:0] pc_out;
   logic        seq_active1, mem_read1, mem_write1, stall1, pc_load1, flags_load1;
   logic [1:0]  mem_addr_sel1;
   logic [2:0]  mem_data_sel1, flags_out1;
   logic [15:0] sp_addr1, sp1;
   logic [31:0] pc_out1;
   logic [15:0] mem [2048];
   logic [15:0] mmem [2048];
   logic [15:0] msp = 16'h07FF;
   int          errors = 0, checks = 0;
   typedef struct packed {
      logic        rd, wr;
      logic [2:0]  ds;
      logic [15:0] addr, d;
      logic        pcl, fll;
      logic [31:0] pc;
      logic [2:0]  fl;
   } beat_t;
   beat_t q[$];
   beat_t e;

   mem_stack_seq u0 (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .mem_rd_data(mem_rd_data),
      .seq_active(seq_active), .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
      .mem_data_sel(mem_data_sel), .sp_addr(sp_addr), .sp(sp), .stall(stall), .pc_out(pc_out),
      .pc_load(pc_load), .flags_out(flags_out), .flags_load(flags_load)
   );
   mem_stack_seq #(.W(16), .SP_INIT(16'h0000)) u1 (
      .clk(clk), .rst(rst), .op_valid(op_valid1), .op_code(op_code), .mem_rd_data(16'h0000),
      .seq_active(seq_active1), .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr_sel(mem_addr_sel1),
      .mem_data_sel(mem_data_sel1), .sp_addr(sp_addr1), .sp(sp1), .stall(stall1), .pc_out(pc_out1),
      .pc_load(pc_load1), .flags_out(flags_out1), .flags_load(flags_load1)
   );

   always #5 clk = ~clk;

   always_comb
      case (mem_data_sel)
         3'd0: wdata = rsrc;
         3'd1: wdata = rdst;
         3'd2: wdata = {13'd0, flags};
         3'd3: wdata = pc[31:16];
         3'd4: wdata = pc[15:0];
         3'd5: wdata = pcp[31:16];
         3'd6: wdata = pcp[15:0];
         default: wdata = 16'd0;
      endcase
   assign mem_rd_data = mem[sp_addr[10:0]];
   always @(posedge clk) if (mem_write) mem[sp_addr[10:0]] <= wdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wb(input logic [2:0] ds, input logic [15:0] d);
      beat_t b = '0;
      b.wr = 1;
      b.ds = ds;
      b.addr = msp;
      mmem[msp[10:0]] = d;
      msp = msp - 16'd1;
      q.push_back(b);
   endtask

   task automatic rb(output beat_t b);
      b = '0;
      b.rd = 1;
      msp = msp + 16'd1;
      b.addr = msp;
      b.d = mmem[msp[10:0]];
   endtask

   task automatic expect_op(input logic [2:0] op);
      beat_t a, b, c;
      case (op)
         3'd1: wb(3'd0, rsrc);
         3'd2: begin rb(a); q.push_back(a); end
         3'd3: begin wb(3'd5, pcp[31:16]); wb(3'd6, pcp[15:0]); end
         3'd4: begin
            rb(a); rb(b);
            b.pcl = 1; b.pc = {b.d, a.d};
            q.push_back(a); q.push_back(b);
         end
         3'd5: begin wb(3'd3, pc[31:16]); wb(3'd4, pc[15:0]); wb(3'd2, {13'd0, flags}); end
         3'd6: begin
            rb(a); rb(b); rb(c);
            c.pcl = 1; c.fll = 1; c.pc = {c.d, b.d}; c.fl = a.d[2:0];
            q.push_back(a); q.push_back(b); q.push_back(c);
         end
         default: ;
      endcase
   endtask

   // entered and left just after a rising edge
   task automatic run_op(input logic [2:0] op, input int n);
      op_valid = 1;
      op_code = op;
      expect_op(op);
      @(negedge clk) check("stall_accept", stall, n > 0);
      @(posedge clk) #1;
      op_valid = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk) check("stall_beat", stall, i < n);
         @(posedge clk) #1;
      end
      check("sp_after_op", sp, msp);
   endtask

   always @(negedge clk)
      if (rst) begin
         if (seq_active) begin
            if (q.size() == 0) check("extra_beat", seq_active, 0);
            else begin
               e = q.pop_front();
               check("beat_ctl", {mem_read, mem_write, e.wr ? mem_data_sel : 3'd0, mem_addr_sel, pc_load, flags_load},
                     {e.rd, e.wr, e.ds, 2'd3, e.pcl, e.fll});
               check("beat_addr", sp_addr, e.addr);
               if (e.pcl) check("pc_out", pc_out, e.pc);
               if (e.fll) check("flags_out", flags_out, e.fl);
            end
         end else
            check("idle_ctl", {mem_read, mem_write, pc_load, flags_load, mem_addr_sel, mem_data_sel, pc_out, flags_out}, 0);
      end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_sp", sp, 16'h07FF);
      check("rst_out", {stall, seq_active, mem_read, mem_write, pc_load, flags_load, sp_addr}, 0);
      check("rst_sp_wrap_inst", sp1, 16'h0000);
      @(negedge clk) rst = 1;
      @(posedge clk) #1;
      pcp = 32'h0001_2345;
      run_op(3'd3, 2);
      run_op(3'd4, 2);
      pc = 32'hABCD_1357;
      flags = 3'b101;
      run_op(3'd5, 3);
      pc = 32'h0;
      flags = 3'b010;
      run_op(3'd6, 3);
      check("post_rti_load", {pc_load, flags_load}, 0);
      rsrc = 16'hBEEF;
      run_op(3'd1, 1);
      run_op(3'd2, 1);
      run_op(3'd0, 0);
      run_op(3'd7, 0);
      rsrc = 16'hCAFE;
      op_valid = 1;
      op_code = 3'd1;
      expect_op(3'd1);
      expect_op(3'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) check("b2b_stall", stall, i % 2 == 0);
         @(posedge clk) #1;
      end
      op_valid = 0;
      check("b2b_sp", sp, msp);
      run_op(3'd2, 1);
      run_op(3'd2, 1);
      pc = 32'h1234_5678;
      op_valid = 1;
      op_code = 3'd5;
      expect_op(3'd5);
      @(posedge clk) #1 op_valid = 0;
      @(posedge clk) #1;
      check("abort_in_beat2", {seq_active, mem_write}, 2'b11);
      #1 rst = 0;
      #1;
      check("abort_out", {seq_active, mem_read, mem_write, pc_load, flags_load, stall, mem_addr_sel, mem_data_sel, sp_addr, pc_out}, 0);
      check("abort_sp", sp, 16'h07FF);
      q.delete();
      msp = 16'h07FF;
      @(negedge clk) #1 rst = 1;
      @(posedge clk) #1;
      rsrc = 16'h5A5A;
      run_op(3'd1, 1);
      run_op(3'd2, 1);
      op_valid1 = 1;
      op_code = 3'd1;
      @(negedge clk) check("wrap_stall", stall1, 1);
      @(posedge clk) #1 op_valid1 = 0;
      @(negedge clk) check("wrap_push", {mem_write1, sp_addr1}, {1'b1, 16'h0000});
      @(posedge clk) #1 check("wrap_sp_dec", sp1, 16'hFFFF);
      op_valid1 = 1;
      op_code = 3'd2;
      @(posedge clk) #1 op_valid1 = 0;
      @(negedge clk) check("wrap_pop", {mem_read1, sp_addr1}, {1'b1, 16'h0000});
      @(posedge clk) #1 check("wrap_sp_inc", sp1, 16'h0000);
      check("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
